control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 35 +++
 rtl/control_unit_loopmux.sv | 18 +
 rtl/control_unit.sv | 194 +++++++++++++++++++
 tb/tb_control_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared types for the loop-sequencing control unit
package control_unit_pkg;

  localparam int ADDR_W = 18;
  localparam int COEF_N = 8;
  localparam int FORMULA_W = 162;
  localparam logic [15:0] PC_START = 16'd6;

  typedef enum logic [1:0] {
    INSTR_TYPE_LOAD_STORE = 2'd0,
    INSTR_TYPE_RAM        = 2'd1,
    INSTR_TYPE_ARITHMETIC = 2'd2,
    INSTR_TYPE_LOOP       = 2'd3
  } instr_type_e;

  typedef enum logic [3:0] {
    IDLE,
    PREPARE_PROGRAM_0,
    PREPARE_PROGRAM_1,
    DECODE,
    START_NEW_LOOP,
    INCREMENT_LOOP,
    UPDATE_APU,
    INSERT_TO_QUEUE,
    UPDATE_PC,
    FINISHED
  } state_e;

  // coef[0] sits at the MSB end, matching the program header word layout
  typedef struct packed {
    logic [0:COEF_N-1][ADDR_W-1:0] coef;
    logic [ADDR_W-1:0]             constant_term;
  } apu_formula_t;

endpackage

// File: rtl/control_unit_loopmux.sv
// rtl/control_unit_loopmux.sv - evaluates one APU address formula against the loop values
module control_unit_loopmux
  import control_unit_pkg::*;
(
  input  apu_formula_t                     formula,
  input  logic [COEF_N-1:0][ADDR_W-1:0]    loop_value,
  output logic [ADDR_W-1:0]                addr
);

  // all arithmetic wraps modulo 2^18
  always_comb begin
    addr = formula.constant_term;
    for (int i = 0; i < COEF_N; i++) begin
      addr = addr + formula.coef[i] * loop_value[i];
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - program sequencer: loop stack, APU address update, queue issue
module control_unit
  import control_unit_pkg::*;
#(
  parameter int LOG_LOOP_CNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  output logic                program_complete,
  output logic [6:0]          program_header_cache_addr,
  input  logic [0:15]         raw_instruction,
  output logic [15:0]         pc,
  input  logic [647:0]        prog_apu_formula,
  input  logic [0:191]        prog_loop_ro_data,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [ADDR_W-1:0]   main_mem_addr,
  output logic [ADDR_W-1:0]   d_cache_addr,
  output logic [ADDR_W-1:0]   d_main_mem_addr,
  output logic                queue_we,
  output logic [1:0]          queue_instr_type,
  output logic [3:0]          queue_copy_count,
  output logic [0:8]          queue_arith_instr,
  output logic [0:2]          queue_ram_instr,
  output logic [0:6]          queue_ld_st_instr,
  output logic                program_error
);

  localparam int N  = 1 << LOG_LOOP_CNT;
  localparam int DW = LOG_LOOP_CNT + 1;

  state_e state, state_next;

  logic [0:15]        instr;
  apu_formula_t       formula        [N];
  logic [ADDR_W-1:0]  apu_addr       [N];
  logic [ADDR_W-1:0]  apu_eval       [N];
  logic [ADDR_W-1:0]  loop_count_cfg [N];
  logic [ADDR_W-1:0]  slot_value     [N];
  logic [ADDR_W-1:0]  slot_count     [N];
  logic [15:0]        slot_target    [N];
  logic [DW-1:0]      depth;

  logic [COEF_N-1:0][ADDR_W-1:0] live_values;
  logic [LOG_LOOP_CNT-1:0]       top_idx;
  logic [LOG_LOOP_CNT-1:0]       push_idx;
  logic [LOG_LOOP_CNT-1:0]       cache_sel;
  logic [LOG_LOOP_CNT-1:0]       main_sel;
  logic                          dec_is_loop;
  logic                          dec_is_start;
  logic                          loop_error;
  logic                          cur_is_end;
  logic                          jump_back;
  logic                          unused_bits;

  assign top_idx   = LOG_LOOP_CNT'(depth - 1'b1);
  assign push_idx  = LOG_LOOP_CNT'(depth);
  assign cache_sel = instr[3:5];
  assign main_sel  = instr[6:8];

  assign dec_is_loop  = instr_type_e'(raw_instruction[0:1]) == INSTR_TYPE_LOOP;
  assign dec_is_start = raw_instruction[3];
  assign loop_error   = (state == DECODE) && dec_is_loop &&
                        (dec_is_start ? (depth == DW'(N)) : (depth == '0));

  assign cur_is_end = (instr_type_e'(instr[0:1]) == INSTR_TYPE_LOOP) && !instr[3];
  assign jump_back  = slot_value[top_idx] < slot_count[top_idx];

  assign program_complete          = (state == FINISHED);
  assign program_header_cache_addr = {6'd0, state == PREPARE_PROGRAM_1};

  // slots above the current depth contribute nothing to any formula
  always_comb begin
    for (int i = 0; i < N; i++) begin
      live_values[i] = (DW'(i) < depth) ? slot_value[i] : '0;
    end
  end

  always_comb begin
    unused_bits = ^instr[12:15];
    for (int i = 0; i < N; i++) begin
      unused_bits = unused_bits ^ (^prog_loop_ro_data[24*i+18 +: 6]);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_apu
    control_unit_loopmux u_loopmux (
      .formula    (formula[g]),
      .loop_value (live_values),
      .addr       (apu_eval[g])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:              state_next = PREPARE_PROGRAM_0;
      PREPARE_PROGRAM_0: state_next = PREPARE_PROGRAM_1;
      PREPARE_PROGRAM_1: state_next = DECODE;
      DECODE: begin
        if (loop_error)        state_next = FINISHED;
        else if (!dec_is_loop) state_next = INSERT_TO_QUEUE;
        else if (dec_is_start) state_next = START_NEW_LOOP;
        else                   state_next = INCREMENT_LOOP;
      end
      START_NEW_LOOP:    state_next = UPDATE_APU;
      INCREMENT_LOOP:    state_next = UPDATE_APU;
      UPDATE_APU:        state_next = UPDATE_PC;
      INSERT_TO_QUEUE:   state_next = UPDATE_PC;
      UPDATE_PC: begin
        if (cur_is_end && !jump_back && depth == DW'(1)) state_next = FINISHED;
        else                                             state_next = DECODE;
      end
      FINISHED:          state_next = FINISHED;
      default:           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pc                <= '0;
      depth             <= '0;
      instr             <= '0;
      queue_we          <= 1'b0;
      queue_instr_type  <= '0;
      queue_copy_count  <= '0;
      queue_arith_instr <= '0;
      queue_ram_instr   <= '0;
      queue_ld_st_instr <= '0;
      cache_addr        <= '0;
      main_mem_addr     <= '0;
      d_cache_addr      <= '0;
      d_main_mem_addr   <= '0;
      program_error     <= 1'b0;
    end else begin
      state    <= state_next;
      queue_we <= 1'b0;
      case (state)
        PREPARE_PROGRAM_0: begin
          for (int k = 0; k < N/2; k++) begin
            formula[k] <= apu_formula_t'(prog_apu_formula[647-FORMULA_W*k -: FORMULA_W]);
          end
          for (int i = 0; i < N; i++) begin
            loop_count_cfg[i] <= prog_loop_ro_data[24*i +: ADDR_W];
          end
        end
        PREPARE_PROGRAM_1: begin
          for (int k = 0; k < N/2; k++) begin
            formula[N/2+k] <= apu_formula_t'(prog_apu_formula[647-FORMULA_W*k -: FORMULA_W]);
          end
          pc <= PC_START;
        end
        DECODE: begin
          instr <= raw_instruction;
          if (loop_error) program_error <= 1'b1;
        end
        START_NEW_LOOP: begin
          slot_value[push_idx]  <= '0;
          slot_count[push_idx]  <= loop_count_cfg[instr[4:6]];
          slot_target[push_idx] <= pc + 16'd1;
          depth                 <= depth + 1'b1;
        end
        INCREMENT_LOOP: begin
          slot_value[top_idx] <= slot_value[top_idx] + 1'b1;
        end
        UPDATE_APU: begin
          for (int k = 0; k < N; k++) apu_addr[k] <= apu_eval[k];
        end
        INSERT_TO_QUEUE: begin
          queue_we          <= 1'b1;
          queue_instr_type  <= instr[0:1];
          queue_copy_count  <= 4'd1;
          queue_arith_instr <= instr[2:10];
          queue_ram_instr   <= {instr[2], instr[9:10]};
          queue_ld_st_instr <= {instr[2], instr[6:11]};
          cache_addr        <= apu_addr[cache_sel];
          main_mem_addr     <= apu_addr[main_sel];
          d_cache_addr      <= (depth == '0) ? '0 : formula[cache_sel].coef[top_idx];
          d_main_mem_addr   <= (depth == '0) ? '0 : formula[main_sel].coef[top_idx];
        end
        UPDATE_PC: begin
          if (cur_is_end && jump_back) begin
            pc <= slot_target[top_idx];
          end else begin
            pc <= pc + 16'd1;
            if (cur_is_end) depth <= depth - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench with a queue-write scoreboard for control_unit
module tb_control_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         program_complete;
  logic [6:0]   program_header_cache_addr;
  logic [0:15]  raw_instruction;
  logic [15:0]  pc;
  logic [647:0] prog_apu_formula;
  logic [0:191] prog_loop_ro_data;
  logic [17:0]  cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
  logic         queue_we;
  logic [1:0]   queue_instr_type;
  logic [3:0]   queue_copy_count;
  logic [0:8]   queue_arith_instr;
  logic [0:2]   queue_ram_instr;
  logic [0:6]   queue_ld_st_instr;
  logic         program_error;

  control_unit #(.LOG_LOOP_CNT(3)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .program_complete          (program_complete),
    .program_header_cache_addr (program_header_cache_addr),
    .raw_instruction           (raw_instruction),
    .pc                        (pc),
    .prog_apu_formula          (prog_apu_formula),
    .prog_loop_ro_data         (prog_loop_ro_data),
    .cache_addr                (cache_addr),
    .main_mem_addr             (main_mem_addr),
    .d_cache_addr              (d_cache_addr),
    .d_main_mem_addr           (d_main_mem_addr),
    .queue_we                  (queue_we),
    .queue_instr_type          (queue_instr_type),
    .queue_copy_count          (queue_copy_count),
    .queue_arith_instr         (queue_arith_instr),
    .queue_ram_instr           (queue_ram_instr),
    .queue_ld_st_instr         (queue_ld_st_instr),
    .program_error             (program_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [17:0] cache;
    logic [17:0] main;
    logic [17:0] dcache;
    logic [17:0] dmain;
    logic [8:0]  arith;
    logic [2:0]  ram;
    logic [6:0]  ldst;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [64];
  logic [17:0] tcoef [8][8];
  logic [17:0] tconst [8];
  logic [17:0] tcount [8];
  int          passed = 0;
  int          total = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  logic        prev_we = 1'b0;

  // combinational icache: the word at pc is valid within the cycle after pc moves
  assign raw_instruction = (pc < 16'd64) ? mem[pc[5:0]] : 16'h0000;

  always_comb begin
    int hs;
    hs = (program_header_cache_addr == 7'd1) ? 4 : 0;
    prog_apu_formula = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        prog_apu_formula[647-162*k-18*j -: 18] = tcoef[hs+k][j];
      end
      prog_apu_formula[647-162*k-144 -: 18] = tconst[hs+k];
    end
  end

  always_comb begin
    prog_loop_ro_data = '0;
    for (int i = 0; i < 8; i++) prog_loop_ro_data[24*i +: 24] = {tcount[i], 6'd0};
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && queue_we) begin
      exp_t e;
      pulses++;
      last_we_cyc = cyc;
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_type", {30'd0, queue_instr_type}, {30'd0, e.typ});
        check("cache_addr", {14'd0, cache_addr}, {14'd0, e.cache});
        check("main_mem_addr", {14'd0, main_mem_addr}, {14'd0, e.main});
        check("d_cache_addr", {14'd0, d_cache_addr}, {14'd0, e.dcache});
        check("d_main_mem_addr", {14'd0, d_main_mem_addr}, {14'd0, e.dmain});
        check("arith_instr", {23'd0, queue_arith_instr}, {23'd0, e.arith});
        check("ram_instr", {29'd0, queue_ram_instr}, {29'd0, e.ram});
        check("ld_st_instr", {25'd0, queue_ld_st_instr}, {25'd0, e.ldst});
        check("copy_count", {28'd0, queue_copy_count}, 32'd1);
      end
    end
    prev_we = queue_we;
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) tcoef[k][j] = '0;
      tconst[k] = '0;
      tcount[k] = '0;
    end
    sb.delete();
    pulses = 0;
  endtask

  // single-loop program model: bit b of the instruction is w[15-b]
  task automatic push_exp(input logic [15:0] w, input int it);
    exp_t e;
    logic [2:0] ac, am;
    ac       = w[12:10];
    am       = w[9:7];
    e.typ    = w[15:14];
    e.cache  = tconst[ac] + tcoef[ac][0] * 18'(it);
    e.main   = tconst[am] + tcoef[am][0] * 18'(it);
    e.dcache = tcoef[ac][0];
    e.dmain  = tcoef[am][0];
    e.arith  = w[13:5];
    e.ram    = {w[13], w[6:5]};
    e.ldst   = {w[13], w[9:4]};
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_we", {31'd0, queue_we}, 32'd0);
    check("rst_complete", {31'd0, program_complete}, 32'd0);
    check("rst_error", {31'd0, program_error}, 32'd0);
    check("rst_cache_addr", {14'd0, cache_addr}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!program_complete && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, program_complete}, 32'd1);
  endtask

  logic [15:0] relu [5];

  initial begin
    // basic loop: one RAM instruction, three iterations
    clear_prog();
    mem[6] = 16'hD000; mem[7] = 16'h4A00; mem[8] = 16'hC000;
    tcount[0] = 18'd3; tcoef[2][0] = 18'd2; tconst[4] = 18'd3;
    for (int it = 0; it < 3; it++) push_exp(16'h4A00, it);
    apply_reset();
    @(negedge clk);
    check("hdr_prep0", {25'd0, program_header_cache_addr}, 32'd0);
    @(negedge clk);
    check("hdr_prep1", {25'd0, program_header_cache_addr}, 32'd1);
    @(negedge clk);
    check("pc_start", {16'd0, pc}, 32'd6);
    check("hdr_decode", {25'd0, program_header_cache_addr}, 32'd0);
    repeat (4) @(negedge clk);
    check("pc_after_start", {16'd0, pc}, 32'd7);
    check("we_before_insert", {31'd0, queue_we}, 32'd0);
    repeat (2) @(negedge clk);
    check("we_first_pulse", {31'd0, queue_we}, 32'd1);
    wait_done("t1_complete", 200);
    check("t1_latency", {31'd0, (cyc - last_we_cyc) <= 10}, 32'd1);
    repeat (5) @(negedge clk);
    check("t1_pulses", pulses, 32'd3);
    check("t1_sb_empty", sb.size(), 32'd0);
    check("t1_pc", {16'd0, pc}, 32'd9);
    check("t1_error", {31'd0, program_error}, 32'd0);

    // RELU body over 256 iterations, formulas wrap mod 2^18, dead slots carry coefficients
    clear_prog();
    relu[0] = 16'h4080; relu[1] = 16'h0000; relu[2] = 16'h8000;
    relu[3] = 16'h0300; relu[4] = 16'h6120;
    mem[6] = 16'hD000;
    for (int i = 0; i < 5; i++) mem[7+i] = relu[i];
    mem[12] = 16'hC000;
    tcount[0] = 18'd256;
    for (int k = 0; k < 8; k++) begin
      tconst[k] = 18'(10*k + 5);
      tcoef[k][0] = 18'(1000*(k+1) + 7);
      for (int j = 1; j < 8; j++) tcoef[k][j] = 18'(3*j + k + 1);
    end
    for (int it = 0; it < 256; it++)
      for (int i = 0; i < 5; i++) push_exp(relu[i], it);
    apply_reset();
    wait_done("relu_complete", 8000);
    repeat (5) @(negedge clk);
    check("relu_pulses", pulses, 32'd1280);
    check("relu_sb_empty", sb.size(), 32'd0);
    check("relu_pc", {16'd0, pc}, 32'd13);

    // reset in the middle of the RELU run aborts it without a queue write
    sb.delete();
    for (int it = 0; it < 256; it++)
      for (int i = 0; i < 5; i++) push_exp(relu[i], it);
    apply_reset();
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_we", {31'd0, queue_we}, 32'd0);
    check("midrst_pc", {16'd0, pc}, 32'd0);
    check("midrst_complete", {31'd0, program_complete}, 32'd0);

    // end_loop with an empty stack
    clear_prog();
    mem[6] = 16'hC000;
    apply_reset();
    wait_done("err_end_complete", 30);
    check("err_end_flag", {31'd0, program_error}, 32'd1);
    repeat (5) @(negedge clk);
    check("err_end_sticky", {31'd0, program_error}, 32'd1);
    check("err_end_pulses", pulses, 32'd0);

    // ninth nested start_loop overflows the eight-slot stack
    clear_prog();
    for (int i = 0; i < 9; i++) mem[6+i] = 16'hD000;
    tcount[0] = 18'd2;
    apply_reset();
    wait_done("err_nest_complete", 100);
    check("err_nest_flag", {31'd0, program_error}, 32'd1);
    check("err_nest_pc", {16'd0, pc}, 32'd14);
    check("err_nest_pulses", pulses, 32'd0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("final_rst_error", {31'd0, program_error}, 32'd0);
    check("final_rst_complete", {31'd0, program_complete}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
